fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's 32-bit FIFO buffer between N_REQ producers.
- Grants one producer at a time, holding the grant for a burst of up to MAX_BURST words.
- Drives the FIFO's WR, EN and dataIn, and back-pressures producers from FULL.
- Sits between producer blocks and the FIFO instance; the read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_write_arbiter_rr_pick.sv | 42 ++++
 rtl/fifo_write_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
// The state enum is used by the top-level controller; widths are shared with the picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int GRANT_ID_W  = 3;
    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask) searching
// upward from ptr+1 with wrap-around modulo N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]      req,
    input  logic [GRANT_ID_W-1:0] ptr,
    input  logic [N_REQ-1:0]      mask,
    output logic                  found,
    output logic [GRANT_ID_W-1:0] index
);

    logic [N_REQ-1:0] cand;
    logic [7:0]       cand_ext;
    logic [3:0]       sum;
    logic [2:0]       idx;

    assign cand     = req & ~mask;
    assign cand_ext = 8'(cand);

    // Scan from the farthest distance to the nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        index = '0;
        sum   = '0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(N_REQ)) begin
                sum = sum - 4'(N_REQ);
            end
            idx = sum[2:0];
            if (cand_ext[idx]) begin
                found = 1'b1;
                index = GRANT_ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
// Accepted words pass straight through combinationally to the FIFO on the same edge.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic                      fifo_en,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [GRANT_ID_W-1:0]     grant_id,
    output logic                      busy
);

    arb_state_t             state_reg, state_next;
    logic [GRANT_ID_W-1:0]  grant_id_reg, grant_id_next;
    logic [BURST_CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [GRANT_ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic                   fifo_en_reg;

    logic [7:0]             valid_ext;
    logic [DATA_W-1:0]      words [8];
    logic [N_REQ-1:0]       owner_mask;
    logic                   owner_valid;
    logic                   xfer;
    logic                   last_beat;
    logic                   idle_found, hand_found;
    logic [GRANT_ID_W-1:0]  idle_idx, hand_idx;

    // Pad producers out to 8 so a 3-bit grant_id can index without width games.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < N_REQ) begin : g_live
                assign valid_ext[gi] = req_valid[gi];
                assign words[gi]     = req_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
                assign words[gi]     = '0;
            end
        end
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign owner_mask[gi] = (grant_id_reg == GRANT_ID_W'(gi));
            assign req_ready[gi]  = xfer & owner_mask[gi];
        end
    endgenerate

    assign busy        = (state_reg == OWN);
    assign owner_valid = valid_ext[grant_id_reg];
    assign xfer        = busy & owner_valid & ~fifo_full & ~Rst;
    assign last_beat   = (burst_cnt_reg == BURST_CNT_W'(MAX_BURST - 1));
    assign fifo_wr     = xfer;
    assign fifo_en     = fifo_en_reg;
    assign fifo_data   = (busy & ~Rst) ? words[grant_id_reg] : '0;
    assign grant_id    = grant_id_reg;

    rr_pick #(.N_REQ(N_REQ)) u_idle_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .mask  ('0),
        .found (idle_found),
        .index (idle_idx)
    );

    rr_pick #(.N_REQ(N_REQ)) u_hand_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .mask  (owner_mask),
        .found (hand_found),
        .index (hand_idx)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            burst_cnt_reg <= '0;
            rr_ptr_reg    <= GRANT_ID_W'(N_REQ - 1);
            fifo_en_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            burst_cnt_reg <= burst_cnt_next;
            rr_ptr_reg    <= rr_ptr_next;
            fifo_en_reg   <= 1'b1;
        end
    end

    // FULL only stalls: it neither releases the grant nor advances the burst count.
    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        burst_cnt_next = burst_cnt_reg;
        rr_ptr_next    = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (idle_found) begin
                    state_next     = OWN;
                    grant_id_next  = idle_idx;
                    burst_cnt_next = '0;
                    rr_ptr_next    = idle_idx;
                end
            end
            OWN: begin
                if ((xfer && last_beat) || !owner_valid) begin
                    burst_cnt_next = '0;
                    if (hand_found) begin
                        grant_id_next = hand_idx;
                        rr_ptr_next   = hand_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by random
// traffic, compared each cycle against an owner/burst-count reference model.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           Clk;
    logic           Rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr;
    logic           fifo_en;
    logic [W-1:0]   fifo_data;
    logic [2:0]     grant_id;
    logic           busy;

    fifo_write_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_en   (fifo_en),
        .fifo_data (fifo_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    // Producer side: words still to send, sequence number, current word.
    int          remain [N];
    int          seq    [N];
    logic [W-1:0] word  [N];
    bit          random_mode = 0;

    // Reference model: current owner (-1 = nobody), words written this burst,
    // most recent winner (search starts after it), fifo_en level.
    int m_owner, m_cnt, m_last;
    bit m_en;
    int writes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int after, input int excl);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (after + k) % N;
            if (idx != excl && req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_producers(input int r0, input int r1, input int r2, input int r3);
        remain[0] = r0; remain[1] = r1; remain[2] = r2; remain[3] = r3;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            word[i] = W'(32'h100 * i);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = random_mode ? ($urandom_range(0, 3) != 0) : (remain[i] > 0);
            req_data[i*W +: W] = word[i];
        end
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance model at the edge.
    task automatic tick();
        bit           exp_wr;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_data;
        int           o, p;
        drive_inputs();
        #4;
        o = m_owner;
        exp_wr = 1'b0;
        if (!Rst && o >= 0) exp_wr = req_valid[o] && !fifo_full;
        exp_ready = exp_wr ? N'(1 << o) : '0;
        exp_data  = (!Rst && o >= 0) ? word[o] : '0;
        check("fifo_wr",   64'(fifo_wr),   64'(exp_wr));
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("fifo_data", 64'(fifo_data), 64'(exp_data));
        check("busy",      64'(busy),      64'(o >= 0));
        check("fifo_en",   64'(fifo_en),   64'(m_en));
        if (o >= 0) check("grant_id", 64'(grant_id), 64'(o));
        @(posedge Clk);
        if (Rst) begin
            m_owner = -1; m_cnt = 0; m_last = N - 1; m_en = 0;
        end else begin
            m_en = 1;
            if (o < 0) begin
                p = pick(m_last, -1);
                if (p >= 0) begin m_owner = p; m_cnt = 0; m_last = p; end
            end else if ((exp_wr && m_cnt == MB - 1) || !req_valid[o]) begin
                p = pick(o, o);
                m_cnt = 0;
                if (p >= 0) begin m_owner = p; m_last = p; end
                else m_owner = -1;
            end else if (exp_wr) begin
                m_cnt++;
            end
        end
        if (exp_wr) begin
            writes++;
            remain[o]--;
            seq[o]++;
            word[o] = random_mode ? W'($urandom) : W'(32'h100 * o + seq[o]);
        end
        #1;
    endtask

    int w0;

    initial begin
        Rst = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        set_producers(100, 100, 100, 100);
        m_owner = -1; m_cnt = 0; m_last = N - 1; m_en = 0;
        drive_inputs();
        @(posedge Clk);
        #1;

        // Reset held 3 cycles with every producer valid.
        tick();
        tick();

        // Single producer: 6 words -> burst of 4, one idle cycle, then 2.
        Rst = 1'b0;
        set_producers(6, 0, 0, 0);
        w0 = writes;
        for (int t = 0; t < 12; t++) tick();
        check("single_writes", 64'(writes - w0), 64'd6);

        // All four producers, two bursts each, handoffs without bubbles.
        set_producers(8, 8, 8, 8);
        w0 = writes;
        for (int t = 0; t < 40; t++) tick();
        check("rr_writes", 64'(writes - w0), 64'd32);

        // Back-pressure on producer 2 after its first word.
        set_producers(0, 0, 4, 0);
        w0 = writes;
        for (int t = 0; t < 20 && !(m_owner == 2 && writes - w0 == 1); t++) tick();
        check("bp_reached", 64'(m_owner == 2 && writes - w0 == 1), 64'd1);
        fifo_full = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        fifo_full = 1'b0;
        for (int t = 0; t < 8; t++) tick();
        check("bp_writes", 64'(writes - w0), 64'd4);

        // Early release: owner 1 runs dry after 2 words, producer 3 takes over.
        set_producers(0, 2, 0, 0);
        w0 = writes;
        for (int t = 0; t < 10 && m_owner != 1; t++) tick();
        check("er_owner1", 64'(grant_id), 64'd1);
        remain[3] = 4;
        for (int t = 0; t < 12; t++) tick();
        check("er_writes", 64'(writes - w0), 64'd6);

        // Reset in the middle of producer 1's burst; producer 0 must win afterwards.
        set_producers(0, 10, 0, 0);
        for (int t = 0; t < 20 && !(m_owner == 1 && m_cnt == 2); t++) tick();
        check("rm_reached", 64'(m_owner == 1 && m_cnt == 2), 64'd1);
        remain[0] = 3;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        tick();
        check("rm_first_owner", 64'(grant_id), 64'd0);
        check("rm_busy", 64'(busy), 64'd1);
        for (int t = 0; t < 10; t++) tick();

        // Random traffic: valid, FULL and occasional reset all randomized.
        random_mode = 1;
        for (int t = 0; t < 400; t++) begin
            Rst       = ($urandom_range(0, 63) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
